systolic_pe: RTL and testbench
==============================

Name: systolic_pe

Overview:
Parametrised systolic processing element, the successor to the 8-bit/19-bit MAC. Each cell is a two-stage pipelined multiply-accumulate with signed or unsigned mode and optional saturation. It forwards A east and B south for array tiling, and uses first/last beat framing to emit one registered dot-product result per frame. The cells are tiled N x M in the systolic matrix multiplier array.

Parameters:
DATA_W, 8, operand width of a and b.
ACC_W, 19, accumulator/result width; must be >= 2*DATA_W (elaboration error otherwise).
SIGNED_MODE, 0, 1 = two's-complement operands and accumulator; 0 = unsigned.
SATURATE, 1, 1 = clamp on overflow; 0 = wrap modulo 2^ACC_W.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous active-high reset.
a_in  in  DATA_W  A operand from west neighbour.
b_in  in  DATA_W  B operand from north neighbour.
in_valid  in  1  a_in/b_in/in_first/in_last qualified this cycle.
in_first  in  1  beat opens a new frame; valid only with in_valid.
in_last  in  1  beat closes the frame; valid only with in_valid.
a_out  out  DATA_W  registered a_in to east neighbour.
b_out  out  DATA_W  registered b_in to south neighbour.
out_valid  out  1  registered in_valid.
out_first  out  1  registered in_first.
out_last  out  1  registered in_last.
result  out  ACC_W  frame dot product; held until the next frame closes.
result_valid  out  1  one-cycle pulse when result updates.
result_ovf  out  1  frame overflowed (saturated or wrapped); qualified by result_valid, held with result.

Behaviour:
- Reset: all outputs 0, pipeline registers 0, state IDLE. Reset overrides every other input on the same edge. Reset mid-frame discards the partial sum; no result is emitted.
- Stage 1, every edge:
  - a_out<=a_in, b_out<=b_in, out_valid/out_first/out_last <= inputs (flags gated by in_valid).
  - prod_q <= a_in*b_in, full 2*DATA_W, signed per SIGNED_MODE.
  - p_valid, p_first, p_last registered alongside prod_q.
- Forwarding latency: 1 cycle, independent of state.
- Stage 2 (acts only when p_valid=1; otherwise acc, state and flags hold):
  - Extend prod_q to ACC_W: sign-extend if SIGNED_MODE, else zero-extend.
  - Start condition: p_first=1, or state IDLE. A beat without first in IDLE is an implicit first.
  - On start: acc <= ext(prod), ovf <= 0.
  - Otherwise: sum = acc + ext(prod), computed at ACC_W+1 bits.
  - Overflow, unsigned: carry out of bit ACC_W-1.
  - Overflow, signed: operands share a sign and the sum's sign differs.
  - On overflow with SATURATE=1: clamp to 2^ACC_W-1 (unsigned), or to the signed max/min in the direction of the operands.
  - On overflow with SATURATE=0: keep the low ACC_W bits.
  - Either way, ovf is set sticky for the frame.
  - If p_last: result <= new acc value, result_ovf <= new ovf, result_valid <= 1 for one cycle, state -> IDLE.
  - Else: state -> ACC.
- Result latency: the last beat sampled at edge N gives result_valid high after edge N+1.
- FSM: IDLE (no open frame) and ACC (frame open).
  - IDLE -> ACC: valid beat without last.
  - ACC -> IDLE: valid beat with last.
  - ACC -> ACC: valid beat with first and not last. This restarts the frame, the partial is dropped, and no result is emitted.
  - first and last on the same beat: single-term frame, result = ext(prod).
- Gaps (in_valid=0) inside a frame are legal and do not disturb acc.

Decomposition:
- Package systolic_pkg:
  - pe_state_t enum {IDLE, ACC}.
  - Default width constants DATA_W=8, ACC_W=19.
  - Pure function sat_add (ACC_W, signed, saturate) returning {sum, ovf}.
- One sub-module: pe_acc_add. This is the combinational extend/add/overflow/clamp datapath instantiated in stage 2, so it can be unit-tested alone.
- The FSM and pipeline registers stay in systolic_pe.

Test Plan:
- Reset, default params: rst=1 for 2 cycles with in_valid=1 toggling -> all outputs 0; after release, result_valid stays 0 until a last beat.
- Frame (1,2),(2,3),(3,4),(4,5),(5,6), first on beat 1, last on beat 5 -> one result_valid pulse 2 edges after beat 5. result=70, result_ovf=0. a_out/b_out track inputs with 1-cycle delay.
- Unsigned overflow: 9 beats of 255*255.
  - SATURATE=1 -> result=524287, ovf=1.
  - SATURATE=0 -> result=60937, ovf=1.
  - A following single-beat frame 2*3 -> result=6, ovf=0.
- SIGNED_MODE=1, frame (-128,-128),(127,-128),(-1,1) -> result=16384-16256-1=127, ovf=0. A single beat (5,-3) with first+last -> result=-15 (0x7FFF1 at 19 bits).
- Framing edge cases:
  - Valid gaps mid-frame -> same result as the gapless frame.
  - Beat without first in IDLE -> implicit start.
  - Re-first mid-frame -> partial dropped, only the second frame's sum emitted.
  - rst asserted mid-frame -> no result_valid, next frame correct.

Source files
------------

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types, default widths and the saturating adder for systolic_pe
package systolic_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } pe_state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 19;
    localparam int SAT_MAX_W  = 64;

    // Adds two acc_w-bit values held in the low bits of SAT_MAX_W-wide words.
    // Returns {sum, ovf}; sum occupies the low acc_w bits of the upper field.
    function automatic logic [SAT_MAX_W:0] sat_add(
        input logic [SAT_MAX_W-1:0] acc,
        input logic [SAT_MAX_W-1:0] addend,
        input int                   acc_w,
        input logic                 is_signed,
        input logic                 saturate
    );
        logic [SAT_MAX_W-1:0] mask;
        logic [SAT_MAX_W-1:0] a_m;
        logic [SAT_MAX_W-1:0] b_m;
        logic [SAT_MAX_W-1:0] sum;
        logic [SAT_MAX_W:0]   wide;
        logic                 carry;
        logic                 sa;
        logic                 sb;
        logic                 ss;
        logic                 ovf;

        mask  = (acc_w >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << acc_w) - SAT_MAX_W'(1));
        a_m   = acc & mask;
        b_m   = addend & mask;
        wide  = {1'b0, a_m} + {1'b0, b_m};
        sum   = wide[SAT_MAX_W-1:0] & mask;
        carry = (wide >> acc_w) != '0;
        sa    = ((a_m >> (acc_w - 1)) & SAT_MAX_W'(1)) != '0;
        sb    = ((b_m >> (acc_w - 1)) & SAT_MAX_W'(1)) != '0;
        ss    = ((sum >> (acc_w - 1)) & SAT_MAX_W'(1)) != '0;
        ovf   = is_signed ? ((sa == sb) && (ss != sa)) : carry;

        if (ovf && saturate) begin
            if (!is_signed) begin
                sum = mask;
            end else if (sa) begin
                sum = ~(mask >> 1) & mask;
            end else begin
                sum = mask >> 1;
            end
        end
        return {sum, ovf};
    endfunction

endpackage

// File: rtl/pe_acc_add.sv
// rtl/pe_acc_add.sv - combinational product extend, accumulate, overflow detect and clamp
module pe_acc_add
    import systolic_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ACC_W       = DEF_ACC_W,
    parameter int SIGNED_MODE = 0,
    parameter int SATURATE    = 1
) (
    input  logic [2*DATA_W-1:0] prod,
    input  logic [ACC_W-1:0]    acc,
    output logic [ACC_W-1:0]    ext,
    output logic [ACC_W-1:0]    sum,
    output logic                ovf
);

    logic [SAT_MAX_W:0] add_res;

    generate
        if (SIGNED_MODE != 0) begin : g_sext
            assign ext = ACC_W'($signed(prod));
        end else begin : g_zext
            assign ext = ACC_W'(prod);
        end
    endgenerate

    assign add_res = sat_add(SAT_MAX_W'(acc), SAT_MAX_W'(ext), ACC_W,
                             SIGNED_MODE != 0, SATURATE != 0);
    assign sum     = add_res[ACC_W:1];
    assign ovf     = add_res[0];

endmodule

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - two-stage pipelined MAC cell with east/south forwarding and framed results
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ACC_W       = DEF_ACC_W,
    parameter int SIGNED_MODE = 0,
    parameter int SATURATE    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              in_valid,
    input  logic              in_first,
    input  logic              in_last,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              out_valid,
    output logic              out_first,
    output logic              out_last,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid,
    output logic              result_ovf
);

    generate
        if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
            $error("systolic_pe: ACC_W must be >= 2*DATA_W");
        end
        if (ACC_W > SAT_MAX_W) begin : g_acc_too_wide
            $error("systolic_pe: ACC_W exceeds sat_add width");
        end
    endgenerate

    logic [2*DATA_W-1:0] prod_d;
    logic [2*DATA_W-1:0] prod_q;
    logic                p_valid;
    logic                p_first;
    logic                p_last;
    logic [ACC_W-1:0]    acc_q;
    logic                ovf_q;
    pe_state_t           state;

    logic [ACC_W-1:0]    ext_prod;
    logic [ACC_W-1:0]    add_sum;
    logic                add_ovf;
    logic                start;
    logic [ACC_W-1:0]    acc_next;
    logic                ovf_next;

    generate
        if (SIGNED_MODE != 0) begin : g_smul
            assign prod_d = (2*DATA_W)'($signed(a_in)) * (2*DATA_W)'($signed(b_in));
        end else begin : g_umul
            assign prod_d = (2*DATA_W)'(a_in) * (2*DATA_W)'(b_in);
        end
    endgenerate

    pe_acc_add #(
        .DATA_W      (DATA_W),
        .ACC_W       (ACC_W),
        .SIGNED_MODE (SIGNED_MODE),
        .SATURATE    (SATURATE)
    ) u_acc_add (
        .prod (prod_q),
        .acc  (acc_q),
        .ext  (ext_prod),
        .sum  (add_sum),
        .ovf  (add_ovf)
    );

    // A beat arriving with no open frame starts one even without first.
    always_comb begin
        start    = p_first || (state == IDLE);
        acc_next = start ? ext_prod : add_sum;
        ovf_next = start ? 1'b0 : (ovf_q | add_ovf);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_out        <= '0;
            b_out        <= '0;
            out_valid    <= 1'b0;
            out_first    <= 1'b0;
            out_last     <= 1'b0;
            prod_q       <= '0;
            p_valid      <= 1'b0;
            p_first      <= 1'b0;
            p_last       <= 1'b0;
            acc_q        <= '0;
            ovf_q        <= 1'b0;
            state        <= IDLE;
            result       <= '0;
            result_valid <= 1'b0;
            result_ovf   <= 1'b0;
        end else begin
            a_out        <= a_in;
            b_out        <= b_in;
            out_valid    <= in_valid;
            out_first    <= in_valid & in_first;
            out_last     <= in_valid & in_last;
            prod_q       <= prod_d;
            p_valid      <= in_valid;
            p_first      <= in_valid & in_first;
            p_last       <= in_valid & in_last;
            result_valid <= 1'b0;
            if (p_valid) begin
                acc_q <= acc_next;
                ovf_q <= ovf_next;
                if (p_last) begin
                    result       <= acc_next;
                    result_ovf   <= ovf_next;
                    result_valid <= 1'b1;
                    state        <= IDLE;
                end else begin
                    state        <= ACC;
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_pe.sv
// tb/tb_systolic_pe.sv - randomized and directed checks of four systolic_pe configurations
module tb_systolic_pe;

    typedef struct packed {
        longint acc;
        logic   ovf;
    } step_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       in_valid;
    logic       in_first;
    logic       in_last;

    logic [7:0]  a_o [4];
    logic [7:0]  b_o [4];
    logic        ov  [4];
    logic        of  [4];
    logic        ol  [4];
    logic [18:0] res [4];
    logic        rv  [4];
    logic        ro  [4];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Index g: bit 1 selects signed operands, bit 0 selects saturation.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        systolic_pe #(
            .DATA_W      (8),
            .ACC_W       (19),
            .SIGNED_MODE (g / 2),
            .SATURATE    (g % 2)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .a_in         (a_in),
            .b_in         (b_in),
            .in_valid     (in_valid),
            .in_first     (in_first),
            .in_last      (in_last),
            .a_out        (a_o[g]),
            .b_out        (b_o[g]),
            .out_valid    (ov[g]),
            .out_first    (of[g]),
            .out_last     (ol[g]),
            .result       (res[g]),
            .result_valid (rv[g]),
            .result_ovf   (ro[g])
        );
    end

    // Reference: exact integer arithmetic, then range-check against the 19-bit window.
    function automatic step_t frame_step(input longint acc, input logic ovf, input logic open,
                                         input logic first, input logic [7:0] a,
                                         input logic [7:0] b, input bit sgn, input bit sat);
        step_t  r;
        longint p;
        longint s;
        longint lo;
        longint hi;
        p  = sgn ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
        lo = sgn ? -262144 : 0;
        hi = sgn ? 262143 : 524287;
        if (first || !open) begin
            r.acc = p;
            r.ovf = 1'b0;
        end else begin
            s     = acc + p;
            r.ovf = ovf;
            if (s > hi || s < lo) begin
                r.ovf = 1'b1;
                if (sat) begin
                    s = (s > hi) ? hi : lo;
                end else begin
                    s = s & 524287;
                    if (sgn && s > 262143) s = s - 524288;
                end
            end
            r.acc = s;
        end
        return r;
    endfunction

    logic       e_v, e_f, e_l;
    logic [7:0] e_a, e_b;
    logic       m_open [4];
    longint     m_acc  [4];
    logic       m_ovf  [4];
    logic       e_rv   [4];
    longint     e_res  [4];
    logic       e_ro   [4];
    step_t      nxt    [4];

    initial begin
        e_v = 0; e_f = 0; e_l = 0; e_a = 0; e_b = 0;
        for (int c = 0; c < 4; c++) begin
            m_open[c] = 0; m_acc[c] = 0; m_ovf[c] = 0;
            e_rv[c] = 0; e_res[c] = 0; e_ro[c] = 0;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_model
        assign nxt[g] = frame_step(m_acc[g], m_ovf[g], m_open[g], e_f, e_a, e_b,
                                   g >= 2, (g % 2) == 1);
    end

    always @(posedge clk) begin
        if (rst) begin
            e_v <= 0; e_f <= 0; e_l <= 0; e_a <= 0; e_b <= 0;
            for (int c = 0; c < 4; c++) begin
                m_open[c] <= 0; m_acc[c] <= 0; m_ovf[c] <= 0;
                e_rv[c] <= 0; e_res[c] <= 0; e_ro[c] <= 0;
            end
        end else begin
            e_a <= a_in;
            e_b <= b_in;
            e_v <= in_valid;
            e_f <= in_valid & in_first;
            e_l <= in_valid & in_last;
            for (int c = 0; c < 4; c++) begin
                e_rv[c] <= 0;
                if (e_v) begin
                    m_acc[c]  <= nxt[c].acc;
                    m_ovf[c]  <= nxt[c].ovf;
                    m_open[c] <= !e_l;
                    if (e_l) begin
                        e_res[c] <= nxt[c].acc;
                        e_ro[c]  <= nxt[c].ovf;
                        e_rv[c]  <= 1;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int c, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s[%0d] t=%0t got %0h expected %0h", name, c, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            check("a_out", c, 64'(a_o[c]), 64'(e_a));
            check("b_out", c, 64'(b_o[c]), 64'(e_b));
            check("out_valid", c, 64'(ov[c]), 64'(e_v));
            check("out_first", c, 64'(of[c]), 64'(e_f));
            check("out_last", c, 64'(ol[c]), 64'(e_l));
            check("result_valid", c, 64'(rv[c]), 64'(e_rv[c]));
            check("result", c, 64'(res[c]), 64'(e_res[c] & 524287));
            check("result_ovf", c, 64'(ro[c]), 64'(e_ro[c]));
        end
    end

    task automatic drive_beat(input logic [7:0] a, input logic [7:0] b,
                              input logic f, input logic l);
        @(negedge clk);
        rst = 0; a_in = a; b_in = b; in_valid = 1; in_first = f; in_last = l;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 0; in_first = 0; in_last = 0;
        end
    endtask

    task automatic expect_res(input string name, input int c, input logic [18:0] val,
                              input logic ovf);
        bit got;
        got = 0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk);
            in_valid = 0; in_first = 0; in_last = 0;
            if (rv[c] === 1'b1) begin
                got = 1;
                check({name, "_res"}, c, 64'(res[c]), 64'(val));
                check({name, "_ovf"}, c, 64'(ro[c]), 64'(ovf));
                check({name, "_model"}, c, 64'(e_res[c] & 524287), 64'(val));
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL %s[%0d] timeout got no result_valid expected pulse", name, c);
        end
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 3))
            0:       return 8'hFF;
            1:       return 8'h80;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1; a_in = 0; b_in = 0; in_valid = 0; in_first = 0; in_last = 0;
        repeat (2) begin
            @(negedge clk);
            in_valid = ~in_valid; in_first = 1; in_last = 1; a_in = 8'hA5; b_in = 8'h5A;
        end
        @(negedge clk);
        check("rst_a_out", 0, 64'(a_o[0]), 64'd0);
        check("rst_result_valid", 1, 64'(rv[1]), 64'd0);
        check("rst_out_valid", 3, 64'(ov[3]), 64'd0);
        rst = 0; in_valid = 0; in_first = 0; in_last = 0;
        idle(3);
        check("post_rst_result_valid", 1, 64'(rv[1]), 64'd0);

        drive_beat(1, 2, 1, 0); drive_beat(2, 3, 0, 0); drive_beat(3, 4, 0, 0);
        drive_beat(4, 5, 0, 0); drive_beat(5, 6, 0, 1);
        expect_res("dot70", 1, 19'd70, 0);

        for (int i = 0; i < 9; i++) drive_beat(8'hFF, 8'hFF, i == 0, i == 8);
        expect_res("usat", 1, 19'd524287, 1);
        check("uwrap_res", 0, 64'(res[0]), 64'd60937);
        check("uwrap_ovf", 0, 64'(ro[0]), 64'd1);
        drive_beat(2, 3, 1, 1);
        expect_res("single6", 1, 19'd6, 0);
        check("single6_wrap", 0, 64'(res[0]), 64'd6);

        drive_beat(8'h80, 8'h80, 1, 0); drive_beat(8'h7F, 8'h80, 0, 0);
        drive_beat(8'hFF, 8'h01, 0, 1);
        expect_res("signed127", 3, 19'd127, 0);
        check("signed127_wrap", 2, 64'(res[2]), 64'd127);
        drive_beat(8'd5, 8'hFD, 1, 1);
        expect_res("signed_m15", 3, 19'h7FFF1, 0);

        drive_beat(1, 2, 1, 0); idle(1); drive_beat(2, 3, 0, 0); idle(2);
        drive_beat(3, 4, 0, 0); drive_beat(4, 5, 0, 0); drive_beat(5, 6, 0, 1);
        expect_res("gaps", 0, 19'd70, 0);

        drive_beat(1, 2, 0, 0); drive_beat(2, 3, 0, 0); drive_beat(3, 4, 0, 0);
        drive_beat(4, 5, 0, 0); drive_beat(5, 6, 0, 1);
        expect_res("implicit_first", 1, 19'd70, 0);

        drive_beat(9, 9, 1, 0); drive_beat(8, 8, 0, 0);
        drive_beat(1, 2, 1, 0); drive_beat(2, 3, 0, 0); drive_beat(3, 4, 0, 0);
        drive_beat(4, 5, 0, 0); drive_beat(5, 6, 0, 1);
        expect_res("refirst", 1, 19'd70, 0);

        drive_beat(7, 7, 1, 0); drive_beat(6, 6, 0, 0);
        @(negedge clk);
        rst = 1; in_valid = 1; in_last = 1;
        @(negedge clk);
        rst = 0; in_valid = 0; in_first = 0; in_last = 0;
        idle(2);
        check("midrst_result", 1, 64'(res[1]), 64'd0);
        check("midrst_result_valid", 1, 64'(rv[1]), 64'd0);
        drive_beat(3, 4, 1, 1);
        expect_res("after_rst", 1, 19'd12, 0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 299) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            in_first = ($urandom_range(0, 9) == 0);
            in_last  = ($urandom_range(0, 11) == 0);
            a_in     = pick();
            b_in     = pick();
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
